// File: rtl/sccb_cam_config.sv
// sccb_cam_config: walks a {reg,value} table and writes each entry over 3-phase SCCB.
// Define CAM_POWER_SEQ_EN to run the pwdn/cam_reset power-up sequence after every resend.
module sccb_cam_config #(
  parameter int CLK_HZ = 50_000_000,
  parameter int SCCB_HZ = 100_000,
  parameter logic [7:0] SID = 8'h60,
  parameter int AW = 8,
  parameter int DELAY_MS = 10,
  parameter int PWDN_MS = 1,
  parameter int RST_MS = 1,
  parameter int BOOT_MS = 2
) (
  input  logic          clk,
  input  logic          resend,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          config_finished,
  output logic          nack_seen,
  output logic          sioc,
  inout  wire           siod,
  output logic          cam_reset,
  output logic          pwdn
);
  localparam int QDIV = CLK_HZ / (4 * SCCB_HZ);
  localparam int MS = CLK_HZ / 1000;
  typedef enum logic [2:0] {
`ifdef CAM_POWER_SEQ_EN
    PWR_DOWN, RST_HOLD, BOOT_WAIT,
`endif
    FETCH, DECODE, WRITE, DELAY, DONE
  } state_t;
`ifdef CAM_POWER_SEQ_EN
  localparam state_t INIT = PWR_DOWN;
`else
  localparam state_t INIT = FETCH;
`endif
  state_t st_q, st_d;
  logic [31:0] tmr_q, tmr_d, lim;
  logic [6:0] qi_q, qi_d, kq;
  logic [15:0] wd_q, wd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic nack_q, nack_d, done_q, scl_q, scl_d, sdl_q, sdl_d, tdone, xs;
  // Bus levels {sioc, drive_low} for quarter q of a 118-quarter write frame.
  function automatic logic [1:0] bus_f(input logic wr, input logic [6:0] q, input logic [26:0] f);
    logic [6:0] k;
    k = q - 7'd3;
    return !wr ? 2'b10 : q < 7'd2 ? 2'b11 : q == 7'd2 ? 2'b01 :
           q < 7'd111 ? {k[1], ~f[5'd26 - k[6:2]]} :
           q == 7'd111 ? 2'b01 : q == 7'd112 ? 2'b11 : 2'b10;
  endfunction
  assign kq = qi_q - 7'd3;
  assign xs = qi_q >= 7'd3 && qi_q < 7'd111 && kq[1:0] == 2'd2 &&
              (kq[6:2] == 5'd8 || kq[6:2] == 5'd17 || kq[6:2] == 5'd26);
  always_comb begin
    st_d = st_q;
    addr_d = addr_q;
    wd_d = wd_q;
    qi_d = qi_q;
    nack_d = nack_q;
    lim = 32'd1;
    case (st_q)
`ifdef CAM_POWER_SEQ_EN
      PWR_DOWN: lim = 32'(PWDN_MS * MS);
      RST_HOLD: lim = 32'(RST_MS * MS);
      BOOT_WAIT: lim = 32'(BOOT_MS * MS);
`endif
      WRITE: lim = 32'(QDIV);
      DELAY: lim = 32'(DELAY_MS * MS);
      default: ;
    endcase
    tdone = tmr_q == lim - 32'd1;
    case (st_q)
`ifdef CAM_POWER_SEQ_EN
      PWR_DOWN: st_d = tdone ? RST_HOLD : st_q;
      RST_HOLD: st_d = tdone ? BOOT_WAIT : st_q;
      BOOT_WAIT: st_d = tdone ? FETCH : st_q;
`endif
      FETCH: st_d = DECODE;
      DECODE: begin
        wd_d = rom_data;
        qi_d = '0;
        st_d = rom_data == 16'hFFFF ? DONE : rom_data == 16'hFFF0 ? DELAY : WRITE;
      end
      WRITE: if (tdone) begin
        qi_d = qi_q + 7'd1;
        nack_d = nack_q | (xs & ~siod);
      end
      default: ;
    endcase
    if (tdone && (st_q == DELAY || (st_q == WRITE && qi_q == 7'd117))) begin
      st_d = addr_q == '1 ? DONE : FETCH;
      addr_d = addr_q == '1 ? addr_q : addr_q + AW'(1);
    end
    tmr_d = st_d != st_q || tdone ? '0 : tmr_q + 32'd1;
    {scl_d, sdl_d} = bus_f(st_d == WRITE, qi_d, {SID, 1'b1, wd_d[15:8], 1'b1, wd_d[7:0], 1'b1});
  end
  always_ff @(posedge clk) begin
    if (resend) begin
      st_q <= INIT;
      tmr_q <= '0;
      qi_q <= '0;
      wd_q <= '0;
      addr_q <= '0;
      nack_q <= 1'b0;
      done_q <= 1'b0;
      scl_q <= 1'b1;
      sdl_q <= 1'b0;
    end else begin
      st_q <= st_d;
      tmr_q <= tmr_d;
      qi_q <= qi_d;
      wd_q <= wd_d;
      addr_q <= addr_d;
      nack_q <= nack_d;
      done_q <= st_d == DONE;
      scl_q <= scl_d;
      sdl_q <= sdl_d;
    end
  end
`ifdef CAM_POWER_SEQ_EN
  always_ff @(posedge clk) begin
    pwdn <= resend || st_d == PWR_DOWN;
    cam_reset <= !resend && st_d != PWR_DOWN && st_d != RST_HOLD;
  end
`else
  assign pwdn = 1'b0;
  assign cam_reset = 1'b1;
`endif
  assign rom_addr = addr_q;
  assign config_finished = done_q;
  assign nack_seen = nack_q;
  assign sioc = scl_q;
  assign siod = sdl_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_sccb_cam_config.sv
// tb_sccb_cam_config: scoreboard bench with an SCCB frame monitor and a NACK-capable sensor model.
module tb_sccb_cam_config;
  localparam int CLK_HZ = 80_000;
  localparam int SCCB_HZ = 10_000;
  localparam int QD = CLK_HZ / (4 * SCCB_HZ);
  localparam int MS = CLK_HZ / 1000;
`ifdef CAM_POWER_SEQ_EN
  localparam int PWR = 4 * MS;
  localparam bit PSEQ = 1'b1;
`else
  localparam int PWR = 0;
  localparam bit PSEQ = 1'b0;
`endif
  logic clk = 1'b0;
  logic resend = 1'b1;
  logic [1:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] rom [4];
  logic config_finished, nack_seen, sioc, cam_reset, pwdn;
  logic sens_low = 1'b0;
  wire siod;
  pullup (siod);
  assign siod = sens_low ? 1'b0 : 1'bz;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [23:0] exp_q [$];
  int nack_idx = -1, fidx = 0, nb = 0, t_start = 0, t_prev = 0;
  bit in_f = 0, have_prev = 0;
  logic psioc = 1'b1, psiod = 1'b1;
  logic [26:0] sh = '0;

  sccb_cam_config #(.CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .SID(8'h60), .AW(2), .DELAY_MS(10),
    .PWDN_MS(1), .RST_MS(1), .BOOT_MS(2)) dut (
    .clk(clk), .resend(resend), .rom_addr(rom_addr), .rom_data(rom_data),
    .config_finished(config_finished), .nack_seen(nack_seen), .sioc(sioc), .siod(siod),
    .cam_reset(cam_reset), .pwdn(pwdn));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (resend) begin
      in_f = 0; nb = 0; fidx = 0; have_prev = 0; sens_low = 1'b0;
    end else begin
      if (sioc && psioc && psiod && !siod) begin
        if (have_prev) check("start_gap", cyc - t_prev, 118 * QD + 2);
        in_f = 1; nb = 0; t_start = cyc; t_prev = cyc; have_prev = 1;
      end else if (in_f && sioc && !psioc && nb < 27) begin
        sh = {sh[25:0], siod};
        nb++;
      end else if (in_f && sioc && psioc && !psiod && siod) begin
        in_f = 0;
        check("frame_len", cyc - t_start, 113 * QD);
        check("frame", {8'h00, sh[26:19], sh[17:10], sh[8:1]},
              exp_q.size() > 0 ? {8'h00, exp_q.pop_front()} : 32'hFFFF_FFFF);
        fidx++;
      end
      if (in_f && psioc && !sioc) sens_low = nb == 26 && fidx == nack_idx;
    end
    psioc = sioc;
    psiod = siod;
  end

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic restart();
    resend = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 6000 && !config_finished; k++) @(negedge clk);
    check(tag, config_finished, 1);
  endtask

  initial begin
    int k, t0;
    load(16'hFF01, 16'h1280, 16'hFFFF, 16'h0000);
    repeat (3) @(negedge clk);
    check("rst_addr", rom_addr, 0);
    check("rst_done", config_finished, 0);
    check("rst_nack", nack_seen, 0);
    check("rst_sioc", sioc, 1);
    check("rst_siod", siod, 1);
    check("rst_pwdn", pwdn, PSEQ);
    check("rst_camrst", cam_reset, !PSEQ);
    exp_q.push_back(24'h60FF01);
    exp_q.push_back(24'h601280);
    resend = 1'b0;
    wait_done("A_done");
    check("A_nack", nack_seen, 0);
    check("A_addr", rom_addr, 2);
    check("A_left", exp_q.size(), 0);
    check("A_idle", {sioc, siod}, 2'b11);

    load(16'hFFF0, 16'h1101, 16'hFFFF, 16'h0000);
    restart();
    exp_q.push_back(24'h601101);
    resend = 1'b0;
    t0 = cyc;
    for (k = 0; k < 3000 && !(sioc && !siod); k++) @(negedge clk);
    check("B_delay", (cyc - t0 >= PWR + 10 * MS) && (cyc - t0 <= PWR + 10 * MS + 6), 1);
    wait_done("B_done");
    check("B_left", exp_q.size(), 0);

    load(16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04);
    nack_idx = 1;
    restart();
    foreach (rom[i]) exp_q.push_back({8'h60, rom[i]});
    resend = 1'b0;
    for (k = 0; k < 3000 && fidx < 1; k++) @(negedge clk);
    check("C_nack_pre", nack_seen, 0);
    for (k = 0; k < 3000 && fidx < 2; k++) @(negedge clk);
    check("C_nack_set", nack_seen, 1);
    wait_done("C_done");
    check("C_nack_hold", nack_seen, 1);
    check("C_left", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    check("C_nowrap", rom_addr, 3);
    check("C_hold", config_finished, 1);

    nack_idx = -1;
    restart();
    foreach (rom[i]) exp_q.push_back({8'h60, rom[i]});
    resend = 1'b0;
    for (k = 0; k < 4000 && !(fidx == 2 && nb == 10 && !sioc); k++) @(negedge clk);
    check("D_reach", k < 4000, 1);
    check("D_left", exp_q.size(), 2);
    resend = 1'b1;
    @(negedge clk);
    check("D_abort", {sioc, siod}, 2'b11);
    check("D_pwdn", pwdn, PSEQ);
    exp_q.delete();
    foreach (rom[i]) exp_q.push_back({8'h60, rom[i]});
    resend = 1'b0;
`ifdef CAM_POWER_SEQ_EN
    for (k = 0; k < 500 && pwdn; k++) @(negedge clk);
    check("D_pwdn_len", k >= MS - 1 && k <= MS + 1, 1);
    for (k = 0; k < 500 && !cam_reset; k++) @(negedge clk);
    check("D_rst_len", k >= MS - 1 && k <= MS + 1, 1);
    for (k = 0; k < 500 && !(sioc && !siod); k++) @(negedge clk);
    check("D_boot_len", k >= 2 * MS - 1 && k <= 2 * MS + 4, 1);
`else
    for (k = 0; k < 500 && !(sioc && !siod); k++) @(negedge clk);
    check("D_start_lat", k >= 1 && k <= 3, 1);
    check("D_pwdn_tie", pwdn, 0);
    check("D_camrst_tie", cam_reset, 1);
`endif
    wait_done("D_done");
    check("D_left", exp_q.size(), 0);
    check("D_addr", rom_addr, 3);
    check("D_nack", nack_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
